// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg
//   Definitions shared by the rom_reader datapath and the dump sequencer:
//   - the dump sequencer state encoding,
//   - the chip-type identifiers used by rom_reader,
//   - the default access time for each supported chip,
//   - the width of the access timer.
package rom_reader_pkg;

    // Width of the access timer. It is also sized for future
    // programming-pulse timing.
    localparam int TIMER_WIDTH = 8;

    // Dump sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_t;

    // Chip types that rom_reader already knows about.
    typedef enum logic [1:0] {
        CHIP_3601   = 2'd0,
        CHIP_556PT4 = 2'd1,
        CHIP_556PT5 = 2'd2
    } chip_type_t;

    // Access time, in clk cycles, for a 3601 and its 556PT4 equivalent.
    localparam int ACCESS_CYCLES_3601 = 4;

    // Returns the default access time for a chip type.
    function automatic logic [TIMER_WIDTH-1:0] default_access_cycles(input chip_type_t chip);
        logic [TIMER_WIDTH-1:0] cycles;
        cycles = TIMER_WIDTH'(ACCESS_CYCLES_3601);
        case (chip)
            CHIP_3601, CHIP_556PT4: cycles = TIMER_WIDTH'(ACCESS_CYCLES_3601);
            CHIP_556PT5:            cycles = TIMER_WIDTH'(6);
            default:                cycles = TIMER_WIDTH'(ACCESS_CYCLES_3601);
        endcase
        return cycles;
    endfunction

endpackage

// File: rtl/rom_access_timer.sv
// rom_access_timer
//   A loadable down-counter that times how long an address is held on the
//   ROM pins. It can also be reused for programming-pulse timing.
//
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset
//     load     in   load 'value' into the counter on this edge
//     value    in   count to load (1..255)
//     expired  out  high when the count reaches zero on the next edge
//                   (the count is 1); also high when the counter is idle at 0
module rom_access_timer
    import rom_reader_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] value,
    output logic                   expired
);

    logic [TIMER_WIDTH-1:0] r_count;

    // NOTE: Sequential state is always written with non-blocking (<=)
    // assignments. Every flop then updates from values sampled before the
    // edge, whatever order the blocks run in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - TIMER_WIDTH'(1);
        end
    end

    // The caller acts on the same edge where the count reaches zero. That is
    // why the flag is raised while the count still reads 1.
    assign expired = (r_count <= TIMER_WIDTH'(1));

endmodule

// File: rtl/rom_dump_sequencer.sv
// rom_dump_sequencer
//   Walks a parallel ROM through an inclusive address range. The range may
//   wrap through the top address. For each address the block:
//     1. drives the address,
//     2. asserts the chip enables,
//     3. waits ACCESS_CYCLES cycles,
//     4. samples the data,
//     5. offers the word on a valid/ready stream.
//
//   Ports:
//     clk, reset_n                  clock and asynchronous active-low reset
//     start, abort                  start a dump (accepted in IDLE only) /
//                                   return to IDLE from any state
//     start_address, end_address    inclusive range, captured at start
//     chip_address, chip_select_n,
//     output_enable_n, chip_data    ROM pins
//     out_data, out_address,
//     out_valid, out_ready          word stream to the host/serial path
//     busy, done, word_count        status: not IDLE / one-cycle end pulse /
//                                   number of words accepted
module rom_dump_sequencer
    import rom_reader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 4,
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_3601
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDRESS_WIDTH-1:0] start_address,
    input  logic [ADDRESS_WIDTH-1:0] end_address,
    output logic [ADDRESS_WIDTH-1:0] chip_address,
    output logic                     chip_select_n,
    output logic                     output_enable_n,
    input  logic [DATA_WIDTH-1:0]    chip_data,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH-1:0] out_address,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH:0]   word_count
);

    localparam logic [TIMER_WIDTH-1:0] LP_ACCESS_CYCLES = TIMER_WIDTH'(ACCESS_CYCLES);

    seq_state_t                r_state;
    seq_state_t                w_next_state;
    logic [ADDRESS_WIDTH-1:0]  r_address;
    logic [ADDRESS_WIDTH-1:0]  r_end_address;
    logic [DATA_WIDTH-1:0]     r_out_data;
    logic [ADDRESS_WIDTH-1:0]  r_out_address;
    logic [ADDRESS_WIDTH:0]    r_word_count;

    logic w_expired;
    logic w_accept_start;
    logic w_handshake;
    logic w_sample;
    logic w_last_word;
    logic w_timer_load;

    // abort outranks start, sampling and the handshake. An aborted cycle
    // therefore changes nothing except the state.
    assign w_accept_start = (r_state == ST_IDLE)    && start && !abort;
    assign w_sample       = (r_state == ST_ACCESS)  && w_expired && !abort;
    assign w_handshake    = (r_state == ST_PRESENT) && out_ready && !abort;
    assign w_last_word    = (r_address == r_end_address);
    // Reload on start, and on every handshake that moves on to another address.
    assign w_timer_load   = w_accept_start || (w_handshake && !w_last_word);

    rom_access_timer u_access_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_timer_load),
        .value   (LP_ACCESS_CYCLES),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: Every output of this block gets a default before the case. A path
    // that forgets to assign a signal then still yields plain logic, not a
    // latch.
    always_comb begin
        w_next_state    = r_state;
        chip_select_n   = 1'b1;
        output_enable_n = 1'b1;
        out_valid       = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                chip_select_n   = 1'b0;
                output_enable_n = 1'b0;
                busy            = 1'b1;
                if (w_expired) w_next_state = ST_PRESENT;
            end
            ST_PRESENT: begin
                chip_select_n   = 1'b0;
                output_enable_n = 1'b0;
                busy            = 1'b1;
                out_valid       = 1'b1;
                if (out_ready) w_next_state = w_last_word ? ST_DONE : ST_ACCESS;
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase

        if (abort) w_next_state = ST_IDLE;
    end

    // Address walk, sampled word and word count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_address     <= '0;
            r_end_address <= '0;
            r_out_data    <= '0;
            r_out_address <= '0;
            r_word_count  <= '0;
        end else begin
            if (w_accept_start) begin
                r_address     <= start_address;
                r_end_address <= end_address;
                r_word_count  <= '0;
            end
            if (w_sample) begin
                r_out_data    <= chip_data;
                r_out_address <= r_address;
            end
            if (w_handshake) begin
                r_word_count <= r_word_count + (ADDRESS_WIDTH + 1)'(1);
                // The increment wraps naturally at the top of the address space.
                if (!w_last_word) r_address <= r_address + ADDRESS_WIDTH'(1);
            end
        end
    end

    assign chip_address = r_address;
    assign out_data     = r_out_data;
    assign out_address  = r_out_address;
    assign word_count   = r_word_count;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Self-checking bench for rom_dump_sequencer.
// A table of ranges is applied first. Multi-cycle corner cases (abort,
// asynchronous reset) follow. Randomized dumps with random backpressure
// close the run. Expected words come from range arithmetic over a ROM array
// held by the bench.
module tb_rom_dump_sequencer;

    localparam int AW = 8;
    localparam int DW = 4;
    localparam int AC = 4;
    localparam int DUMP_BUDGET = 5000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] start_address;
    logic [AW-1:0] end_address;
    logic [AW-1:0] chip_address;
    logic          chip_select_n;
    logic          output_enable_n;
    logic [DW-1:0] chip_data;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_address;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [AW:0]   word_count;

    logic [DW-1:0] rom [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // ROM chip model: it drives data only while both enables are asserted.
    assign chip_data = (!chip_select_n && !output_enable_n) ? rom[chip_address] : '0;

    rom_dump_sequencer #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .ACCESS_CYCLES (AC)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .start_address   (start_address),
        .end_address     (end_address),
        .chip_address    (chip_address),
        .chip_select_n   (chip_select_n),
        .output_enable_n (output_enable_n),
        .chip_data       (chip_data),
        .out_data        (out_data),
        .out_address     (out_address),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy),
        .done            (done),
        .word_count      (word_count)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW-1:0] ea;
        int            stall_word;
        int            stall_cycles;
        int            exp_words;
    } vec_t;

    // Runs one dump from IDLE and checks every word against the ROM array.
    // Word i must come from address sa+i (mod 256). When 'timing' is set,
    // each new word must appear AC+1 cycles after the previous handshake
    // (for the first word, after the start edge).
    task automatic run_dump(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                            input int stall_word, input int stall_cycles,
                            input bit rnd_ready, input int exp_words, input bit timing);
        int            cyc = 0;
        int            hs = 0;
        int            last_hs_cyc = 0;
        int            stall_left = stall_cycles;
        int            addr_err = 0;
        int            hold_err = 0;
        int            data_err = 0;
        int            time_err = 0;
        bit            finished = 0;
        bit            fresh = 1;
        bit            waiting = 0;
        bit            ready;
        logic [AW-1:0] exp_addr;
        logic [AW-1:0] held_addr = '0;
        logic [DW-1:0] held_data = '0;

        @(negedge clk);
        start = 1'b1; start_address = sa; end_address = ea; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        start_address = AW'($urandom);   // don't-care after capture
        end_address   = AW'($urandom);
        check("busy_after_start", busy, 1);

        while (!finished && cyc < DUMP_BUDGET) begin
            cyc++;
            exp_addr = AW'(sa + AW'(hs));
            if (done) begin
                finished = 1;
                if (busy !== 1'b1 || chip_select_n !== 1'b1 || out_valid !== 1'b0) addr_err++;
            end else begin
                if (chip_select_n !== 1'b0 || output_enable_n !== 1'b0 ||
                    chip_address !== exp_addr || busy !== 1'b1) addr_err++;
                if (waiting && (out_valid !== 1'b1 || out_data !== held_data ||
                                out_address !== held_addr)) hold_err++;
                if (out_valid === 1'b1) begin
                    if (fresh) begin
                        fresh = 0;
                        if (timing && (cyc - last_hs_cyc) != AC + 1) time_err++;
                        if (out_address !== exp_addr || out_data !== rom[exp_addr]) data_err++;
                    end
                    if (hs == stall_word && stall_left > 0) begin
                        ready = 0;
                        stall_left--;
                    end else begin
                        ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                    out_ready = ready;
                    if (ready) begin
                        hs++;
                        last_hs_cyc = cyc;
                        fresh = 1;
                        waiting = 0;
                    end else begin
                        waiting = 1;
                        held_addr = out_address;
                        held_data = out_data;
                    end
                end else begin
                    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                    waiting = 0;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;

        check("dump_finished", finished, 1);
        check("handshakes", hs, exp_words);
        check("word_count", word_count, exp_words);
        check("word_data", data_err, 0);
        check("chip_pins", addr_err, 0);
        check("held_while_stalled", hold_err, 0);
        check("word_spacing", time_err, 0);
        check("idle_after_done", {busy, done}, 0);
    endtask

    vec_t vecs[5];

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start_address = '0; end_address = '0;
        for (int a = 0; a < 256; a++) rom[a] = DW'(a) ^ 4'hA;

        // Reset state
        #1;
        check("rst_state", {chip_address, chip_select_n, output_enable_n, out_data,
                            out_address, out_valid, busy, done, word_count},
              {8'h00, 1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 9'd0});
        #12 reset_n = 1'b1;

        // Table-driven ranges: basic, backpressure on word 2, wrap, single word, full chip.
        vecs[0] = '{sa: 8'h10, ea: 8'h13, stall_word: -1, stall_cycles: 0, exp_words: 4};
        vecs[1] = '{sa: 8'h10, ea: 8'h13, stall_word: 1,  stall_cycles: 7, exp_words: 4};
        vecs[2] = '{sa: 8'hFE, ea: 8'h01, stall_word: -1, stall_cycles: 0, exp_words: 4};
        vecs[3] = '{sa: 8'h55, ea: 8'h55, stall_word: -1, stall_cycles: 0, exp_words: 1};
        vecs[4] = '{sa: 8'h00, ea: 8'hFF, stall_word: -1, stall_cycles: 0, exp_words: 256};
        for (int v = 0; v < 5; v++)
            run_dump(vecs[v].sa, vecs[v].ea, vecs[v].stall_word, vecs[v].stall_cycles,
                     1'b0, vecs[v].exp_words, 1'b1);

        // Abort in PRESENT of word 3 together with out_ready; a start pulse
        // mid-dump must be ignored.
        begin
            int            hs = 0;
            int            cyc = 0;
            bit            start_pulsed = 0;
            bit            aborted = 0;
            logic [AW-1:0] second_addr = '0;
            int            stray = 0;
            @(negedge clk);
            start = 1'b1; start_address = 8'h10; end_address = 8'h20; out_ready = 1'b1;
            while (!aborted && cyc < 200) begin
                @(negedge clk);
                cyc++;
                start = 1'b0;
                if (!start_pulsed && hs == 1 && out_valid === 1'b0) begin
                    start = 1'b1; start_address = 8'h80; start_pulsed = 1;
                end else if (out_valid === 1'b1) begin
                    if (hs == 1) second_addr = out_address;
                    if (hs == 2) begin
                        abort = 1'b1;
                        aborted = 1;
                    end else begin
                        hs++;
                    end
                end
            end
            check("abort_reached", aborted, 1);
            @(negedge clk);
            abort = 1'b0; out_ready = 1'b0;
            check("second_word_addr", second_addr, 8'h11);
            check("abort_idle", {busy, out_valid, chip_select_n, output_enable_n, done},
                  {1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
            check("abort_word_count", word_count, 2);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (done !== 1'b0 || busy !== 1'b0) stray++;
            end
            check("abort_no_done", stray, 0);
        end

        // Asynchronous reset during ACCESS of word 2, then a normal dump.
        begin
            int cyc = 0;
            bit seen_valid = 0;
            bit in_access = 0;
            @(negedge clk);
            start = 1'b1; start_address = 8'h30; end_address = 8'h35; out_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (!in_access && cyc < 100) begin
                if (out_valid === 1'b1) seen_valid = 1;
                else if (seen_valid && busy === 1'b1) in_access = 1;
                if (!in_access) @(negedge clk);
                cyc++;
            end
            check("reached_access_word2", in_access, 1);
            check("pre_reset_count", word_count, 1);
            #2 reset_n = 1'b0;
            #1;
            check("async_rst_pins", {chip_address, chip_select_n, output_enable_n},
                  {8'h00, 1'b1, 1'b1});
            check("async_rst_status", {out_data, out_address, out_valid, busy, done, word_count},
                  {4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 9'd0});
            @(negedge clk);
            reset_n = 1'b1; out_ready = 1'b0;
            check("no_done_after_reset", done, 0);
            run_dump(8'h40, 8'h42, -1, 0, 1'b0, 3, 1'b1);
        end

        // Randomized dumps with random ROM contents and random backpressure.
        for (int r = 0; r < 8; r++) begin
            logic [AW-1:0] sa;
            int            len;
            for (int a = 0; a < 256; a++) rom[a] = DW'($urandom);
            sa  = AW'($urandom);
            len = $urandom_range(1, 24);
            run_dump(sa, AW'(sa + AW'(len - 1)), -1, 0, 1'b1, len, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_dump_sequencer.md
Name: rom_dump_sequencer

Overview:
- Sequences a parallel ROM chip (556PT4-class) through an address range and presents each word on a valid/ready stream.
- Per word: drives the address, asserts chip enables, waits a programmable access time, samples the data and pushes it downstream.
- Sits between the rom_reader datapath (chip pins) and the host/serial output path.
- Replaces manual increment/decrement stepping for full-chip dumps.

Parameters:
- ADDRESS_WIDTH, 8: width of the chip address bus and range registers.
- DATA_WIDTH, 4: width of a chip data word.
- ACCESS_CYCLES, 4: clk cycles an address is held before data is sampled. Legal range 1..255.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE; begins a dump.
- abort  in  1  synchronous; returns to IDLE from any state.
- start_address  in  ADDRESS_WIDTH  first address; captured when start is accepted.
- end_address  in  ADDRESS_WIDTH  last address, inclusive; captured when start is accepted.
- chip_address  out  ADDRESS_WIDTH  address pins to the ROM.
- chip_select_n  out  1  active-low chip select.
- output_enable_n  out  1  active-low output enable.
- chip_data  in  DATA_WIDTH  ROM data pins.
- out_data  out  DATA_WIDTH  sampled word.
- out_address  out  ADDRESS_WIDTH  address of out_data.
- out_valid  out  1  word available.
- out_ready  in  1  downstream accepts the word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.
- word_count  out  ADDRESS_WIDTH+1  words accepted in the current or last dump.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - chip_address=0, chip_select_n=1, output_enable_n=1.
  - out_data=0, out_address=0, out_valid=0, busy=0, done=0, word_count=0.
- States: IDLE, ACCESS, PRESENT, DONE.
- IDLE:
  - Chip enables are deasserted.
  - If start=1 at edge N: capture start_address and end_address, clear word_count, load wait counter=ACCESS_CYCLES, go to ACCESS.
  - busy=1 from cycle N+1.
- ACCESS:
  - chip_address=current address, chip_select_n=0, output_enable_n=0.
  - The counter decrements each cycle.
  - On the edge where the counter reaches 0: latch chip_data into out_data and the current address into out_address, then go to PRESENT.
  - Timing: address is driven from N+1, chip_data is sampled at the end of cycle N+ACCESS_CYCLES, out_valid=1 from cycle N+ACCESS_CYCLES+1.
- PRESENT:
  - out_valid=1; out_data and out_address are held stable until out_valid&out_ready.
  - Chip enables stay asserted.
  - On handshake: word_count+1.
    - If the current address equals end_address: go to DONE.
    - Otherwise: address+1 (wraps modulo 2^ADDRESS_WIDTH), reload the counter, go to ACCESS.
  - With out_ready held high, words are spaced ACCESS_CYCLES+1 cycles apart.
- DONE: done=1 and busy=1 for exactly one cycle, chip enables deasserted, then IDLE.
- Address range:
  - start_address > end_address: the walk wraps through the maximum address to end_address.
  - start_address == end_address: exactly one word.
  - Full range: 2^ADDRESS_WIDTH words, so word_count reaches 256 for ADDRESS_WIDTH=8.
- abort=1 in any state:
  - Next state is IDLE; out_valid drops next cycle; chip enables deassert.
  - No done pulse; word_count is held.
  - abort has priority over start and over a handshake in the same cycle.
- start while busy is ignored. Range inputs are don't-care after capture.
- out_valid never drops without a handshake, except on abort or reset.
- Reset mid-operation: outputs take reset values immediately (asynchronous); no done pulse.

Decomposition:
- Shared package rom_reader_pkg:
  - state encoding constants (IDLE/ACCESS/PRESENT/DONE);
  - default ACCESS_CYCLES per supported chip (3601=4);
  - chip-type identifiers already used by rom_reader.
- One sub-module, rom_access_timer:
  - loadable down-counter, 8 bits, inputs load/value, output expired;
  - reusable for future programming-pulse timing.

Test Plan:
- Basic dump: reset, start_address=0x10, end_address=0x13, out_ready=1, ROM model returns address[3:0] ^ 4'hA -> four words 0xA,0xB,0x8,0x9 with out_address 0x10..0x13; first out_valid 5 cycles after start; spacing 5 cycles; done pulses once; word_count=4.
- Backpressure: same range, out_ready=0 for 7 cycles on word 2 -> out_data/out_address held stable and out_valid continuously high; sequence unchanged; no word lost or duplicated.
- Wrap and single word: start=0xFE, end=0x01 -> 4 words at 0xFE,0xFF,0x00,0x01. start=end=0x55 -> 1 word, done, word_count=1.
- Full chip: start=0x00, end=0xFF -> 256 handshakes, word_count=256, chip_address never outside 0..0xFF, single done.
- Abort: abort during PRESENT of word 3 with out_ready=1 in the same cycle -> IDLE next cycle, no handshake counted (word_count=2), no done, chip_select_n=1; start asserted mid-dump is ignored.
- Asynchronous reset during ACCESS (reset_n low between clock edges) -> all outputs at reset values immediately; a new start after release runs the normal latency.
